// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite signal bundle between a master (or bus fabric) and one SRAM slave.
interface ahb_sram_slave_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic [1:0]  hresp;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
        input  hrdata, hreadyout, hresp
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
        output hrdata, hreadyout, hresp
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: word storage with byte/half lanes, a fixed number of
// wait states per OKAY data phase, and the two-cycle ERROR response.
//
// state  | meaning
// S_IDLE | bus ready; completes a pending legal data phase, may accept
// S_WAIT | wait states of a legal data phase, hreadyout low
// S_ERR1 | first ERROR cycle, hreadyout low
// S_ERR2 | second ERROR cycle, hreadyout high, may accept
module ahb_sram_slave #(
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic             hclk,
    input  logic             hrst,
    ahb_sram_slave_if.slave  bus
);
    localparam int          AW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        dphase_q, dphase_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;

    logic [31:0] mem_q [MEM_DEPTH];

    logic          ready;
    logic          accept;
    logic          misaligned;
    logic          out_of_range;
    logic          legal;
    logic          complete;
    logic [AW-1:0] word_idx;
    logic [3:0]    lane_en;
    logic          unused_bits;

    assign ready  = (state_q == S_IDLE) || (state_q == S_ERR2);
    assign accept = ready && bus.hsel && bus.hready && bus.htrans[1];

    assign misaligned   = ((bus.hsize == 3'd1) && bus.haddr[0]) ||
                          ((bus.hsize == 3'd2) && (bus.haddr[1:0] != 2'b00));
    assign out_of_range = {2'b00, bus.haddr[31:2]} >= DEPTH_W;
    assign legal        = (bus.hsize <= 3'd2) && !misaligned && !out_of_range;

    // A legal data phase finishes in the first IDLE cycle after its wait states.
    assign complete = (state_q == S_IDLE) && dphase_q;
    assign word_idx = addr_q[AW+1:2];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dphase_d = dphase_q;
        write_d  = write_q;
        size_d   = size_q;
        addr_d   = addr_q;
        unique case (state_q)
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_IDLE;
                end
            end
            S_ERR1: begin
                state_d = S_ERR2;
            end
            default: begin
                state_d  = S_IDLE;
                dphase_d = 1'b0;
                if (accept) begin
                    addr_d  = bus.haddr;
                    write_d = bus.hwrite;
                    size_d  = bus.hsize[1:0];
                    if (!legal) begin
                        state_d = S_ERR1;
                    end else begin
                        dphase_d = 1'b1;
                        if (WAIT_STATES > 0) begin
                            state_d = S_WAIT;
                            cnt_d   = 4'(WAIT_STATES);
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hrst) begin
        if (!hrst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            dphase_q <= 1'b0;
            write_q  <= 1'b0;
            size_q   <= 2'd0;
            addr_q   <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dphase_q <= dphase_d;
            write_q  <= write_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
        end
    end

    always_comb begin
        lane_en = 4'b0000;
        case (size_q)
            2'd0:    lane_en = 4'b0001 << addr_q[1:0];
            2'd1:    lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    end

    // Storage is deliberately not reset; a reset clears dphase_q so no commit follows.
    always_ff @(posedge hclk) begin
        if (complete && write_q) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem_q[word_idx][8*i +: 8] <= bus.hwdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.hreadyout = ready;
    assign bus.hresp     = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? 2'b01 : 2'b00;
    assign bus.hrdata    = (complete && !write_q) ? mem_q[word_idx] : 32'd0;

    assign unused_bits = ^{addr_q[31:AW+2], bus.hburst};
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Two slaves (0 and 3 wait states) share one driver; a transaction-level
// schedule model predicts hreadyout/hresp/hrdata of the selected slave per cycle.
module tb_ahb_sram_slave;
    localparam int DEPTH = 1024;
    localparam int NREG  = 20;

    typedef enum int {K_NONE, K_RD, K_WR} kind_t;
    typedef struct {
        logic        rdy;
        logic [1:0]  resp;
        kind_t       kind;
        logic [31:0] addr;
        logic [2:0]  size;
    } ent_t;

    logic hclk = 1'b0;
    logic hrst = 1'b0;
    always #5 hclk = ~hclk;

    logic        m_hsel   = 1'b0;
    logic [31:0] m_haddr  = 32'd0;
    logic [1:0]  m_htrans = 2'd0;
    logic        m_hwrite = 1'b0;
    logic [2:0]  m_hsize  = 3'd0;
    logic [2:0]  m_hburst = 3'd0;
    logic [31:0] m_hwdata = 32'd0;
    bit          act      = 1'b0;
    logic        hready_bus;

    ahb_sram_slave_if b0 ();
    ahb_sram_slave_if b3 ();

    ahb_sram_slave #(.MEM_DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (.hclk(hclk), .hrst(hrst), .bus(b0));
    ahb_sram_slave #(.MEM_DEPTH(DEPTH), .WAIT_STATES(3)) dut3 (.hclk(hclk), .hrst(hrst), .bus(b3));

    assign hready_bus = act ? b3.hreadyout : b0.hreadyout;

    assign b0.hsel   = m_hsel & ~act;
    assign b0.haddr  = m_haddr;
    assign b0.htrans = m_htrans;
    assign b0.hwrite = m_hwrite;
    assign b0.hsize  = m_hsize;
    assign b0.hburst = m_hburst;
    assign b0.hwdata = m_hwdata;
    assign b0.hready = hready_bus;

    assign b3.hsel   = m_hsel & act;
    assign b3.haddr  = m_haddr;
    assign b3.htrans = m_htrans;
    assign b3.hwrite = m_hwrite;
    assign b3.hsize  = m_hsize;
    assign b3.hburst = m_hburst;
    assign b3.hwdata = m_hwdata;
    assign b3.hready = hready_bus;

    int checks   = 0;
    int failures = 0;

    function automatic void check(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, want, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    logic [7:0] mb [2][4*DEPTH];
    ent_t       q[$];
    int         cyc           = 0;
    int         err_cycles    = 0;
    int         low_total     = 0;
    int         last_done_cyc = 0;
    logic [31:0] last_rd      = 32'd0;

    function automatic bit model_legal(logic [31:0] a, logic [2:0] sz);
        if (sz > 3'd2) return 1'b0;
        if ((a % (32'd1 << sz)) != 32'd0) return 1'b0;
        return a < 32'(4*DEPTH);
    endfunction

    function automatic logic [31:0] model_rd(int d, logic [31:0] a);
        int base;
        base = int'(a & 32'hFFFF_FFFC);
        return {mb[d][base+3], mb[d][base+2], mb[d][base+1], mb[d][base]};
    endfunction

    function automatic void model_wr(int d, logic [31:0] a, logic [2:0] sz, logic [31:0] wd);
        for (int i = 0; i < (1 << sz); i++) begin
            int b;
            b = int'(a) + i;
            mb[d][b] = wd[8*(b%4) +: 8];
        end
    endfunction

    function automatic logic [31:0] word_addr(int w);
        return (w < NREG) ? 32'(4*w) : 32'(4*(DEPTH - 2 + w - NREG));
    endfunction

    always @(negedge hclk) begin
        ent_t        e;
        logic [31:0] exp_rd, a_rd, i_rd;
        logic        a_rdy, i_rdy;
        logic [1:0]  a_resp, i_resp;
        int          ws;
        cyc++;
        a_rdy  = act ? b3.hreadyout : b0.hreadyout;
        a_resp = act ? b3.hresp     : b0.hresp;
        a_rd   = act ? b3.hrdata    : b0.hrdata;
        i_rdy  = act ? b0.hreadyout : b3.hreadyout;
        i_resp = act ? b0.hresp     : b3.hresp;
        i_rd   = act ? b0.hrdata    : b3.hrdata;
        if (!hrst) begin
            q.delete();
            check("reset_hreadyout", a_rdy, 1);
            check("reset_hresp", a_resp, 0);
            check("reset_hrdata", a_rd, 0);
        end else begin
            if (q.size() > 0) e = q[0];
            else e = '{rdy: 1'b1, resp: 2'b00, kind: K_NONE, addr: 32'd0, size: 3'd0};
            exp_rd = (e.kind == K_RD) ? model_rd(int'(act), e.addr) : 32'd0;
            check("hreadyout", a_rdy, e.rdy);
            check("hresp", a_resp, e.resp);
            check("hrdata", a_rd, exp_rd);
            check("unselected_hreadyout", i_rdy, 1);
            check("unselected_hresp", i_resp, 0);
            check("unselected_hrdata", i_rd, 0);
            if (a_resp != 2'b00) err_cycles++;
            if (!a_rdy && a_resp == 2'b00) low_total++;
            if (e.kind == K_RD) begin
                last_rd       = a_rd;
                last_done_cyc = cyc;
            end
            if (e.kind == K_WR) begin
                model_wr(int'(act), e.addr, e.size, m_hwdata);
                last_done_cyc = cyc;
            end
            if (q.size() > 0) void'(q.pop_front());
            if (m_hsel && m_htrans[1] && e.rdy) begin
                if (!model_legal(m_haddr, m_hsize)) begin
                    q.push_back('{rdy: 1'b0, resp: 2'b01, kind: K_NONE, addr: m_haddr, size: m_hsize});
                    q.push_back('{rdy: 1'b1, resp: 2'b01, kind: K_NONE, addr: m_haddr, size: m_hsize});
                end else begin
                    ws = act ? 3 : 0;
                    for (int i = 0; i < ws; i++)
                        q.push_back('{rdy: 1'b0, resp: 2'b00, kind: K_NONE, addr: m_haddr, size: m_hsize});
                    q.push_back('{rdy: 1'b1, resp: 2'b00, kind: (m_hwrite ? K_WR : K_RD),
                                  addr: m_haddr, size: m_hsize});
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic xfer(input bit sel, input logic [1:0] tr, input bit wr,
                        input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int n;
        n = 0;
        m_hsel   = sel;
        m_htrans = tr;
        m_hwrite = wr;
        m_hsize  = sz;
        m_haddr  = a;
        forever begin
            @(negedge hclk);
            if (hready_bus) break;
            n++;
            if (n > 40) begin
                checks++;
                failures++;
                $display("FAIL xfer_timeout: hready low for %0d cycles, required high within 40", n);
                break;
            end
        end
        @(posedge hclk);
        #1;
        m_hwdata = wd;
        m_htrans = 2'b00;
    endtask

    task automatic drain();
        int n;
        n = 0;
        m_htrans = 2'b00;
        m_hsel   = 1'b0;
        forever begin
            @(posedge hclk);
            #1;
            if (q.size() == 0 && hready_bus) break;
            n++;
            if (n > 60) begin
                checks++;
                failures++;
                $display("FAIL drain_timeout: %0d entries still pending, required 0", q.size());
                break;
            end
        end
    endtask

    task automatic rand_xfer();
        int          r, w;
        logic [31:0] base, off;
        logic [2:0]  sz;
        r        = $urandom_range(0, 99);
        w        = $urandom_range(0, NREG + 1);
        base     = word_addr(w);
        sz       = 3'($urandom_range(0, 2));
        m_hburst = 3'($urandom_range(0, 7));
        if (r < 8) begin
            xfer(1'b1, 2'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz, base, $urandom);
        end else if (r < 14) begin
            xfer(1'b0, 2'($urandom_range(2, 3)), 1'($urandom_range(0, 1)), sz, base, $urandom);
        end else if (r < 26) begin
            case ($urandom_range(0, 2))
                0: begin
                    sz  = 3'($urandom_range(1, 2));
                    off = (sz == 3'd1) ? 32'(2*$urandom_range(0, 1) + 1) : 32'($urandom_range(1, 3));
                    xfer(1'b1, 2'b10, 1'($urandom_range(0, 1)), sz, base + off, $urandom);
                end
                1: begin
                    off = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC
                                                      : 32'(4*DEPTH + 4*$urandom_range(0, 5000));
                    xfer(1'b1, 2'b10, 1'($urandom_range(0, 1)), 3'd2, off, $urandom);
                end
                default: begin
                    xfer(1'b1, 2'b10, 1'($urandom_range(0, 1)), 3'($urandom_range(3, 7)), base, $urandom);
                end
            endcase
        end else begin
            case (sz)
                3'd0:    off = 32'($urandom_range(0, 3));
                3'd1:    off = 32'(2*$urandom_range(0, 1));
                default: off = 32'd0;
            endcase
            xfer(1'b1, 2'($urandom_range(2, 3)), 1'($urandom_range(0, 1)), sz, base + off, $urandom);
        end
    endtask

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] wd;
        int          s, e0, lt0;

        repeat (3) @(posedge hclk);
        #3 hrst = 1'b1;
        @(posedge hclk);
        #1;
        check("post_reset_hreadyout", b0.hreadyout, 1);
        check("post_reset_hresp", b0.hresp, 0);
        check("post_reset_hrdata", b0.hrdata, 0);

        for (int d = 0; d < 2; d++) begin
            act = (d == 1);
            for (int w = 0; w < NREG + 2; w++)
                xfer(1'b1, 2'b10, 1'b1, 3'd2, word_addr(w), $urandom);
            drain();
        end

        // zero-wait slave: back-to-back write then read of the same word
        act = 1'b0;
        xfer(1'b1, 2'b10, 1'b1, 3'd2, 32'h40, 32'hDEAD_BEEF);
        xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h40, $urandom);
        drain();
        check("wr_rd_0x40", last_rd, 32'hDEAD_BEEF);

        xfer(1'b1, 2'b10, 1'b1, 3'd2, 32'h0, 32'h1122_3344);
        wd = $urandom;
        wd[23:16] = 8'hAA;
        xfer(1'b1, 2'b10, 1'b1, 3'd0, 32'h2, wd);
        xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h0, $urandom);
        drain();
        check("byte_lane2", last_rd, 32'h11AA_3344);
        wd = $urandom;
        wd[15:0] = 16'hBEEF;
        xfer(1'b1, 2'b10, 1'b1, 3'd1, 32'h0, wd);
        xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h0, $urandom);
        drain();
        check("half_lane0", last_rd, 32'h11AA_BEEF);

        e0 = err_cycles;
        xfer(1'b1, 2'b10, 1'b1, 3'd2, 32'h2, 32'hFFFF_FFFF);
        xfer(1'b1, 2'b10, 1'b1, 3'd2, 32'(4*DEPTH), 32'hFFFF_FFFF);
        xfer(1'b1, 2'b10, 1'b1, 3'd3, 32'h0, 32'hFFFF_FFFF);
        xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h0, $urandom);
        drain();
        check("error_cycles", 32'(err_cycles - e0), 6);
        check("error_no_write", last_rd, 32'h11AA_BEEF);

        xfer(1'b1, 2'b01, 1'b1, 3'd2, 32'h0, 32'hFFFF_FFFF);
        xfer(1'b0, 2'b10, 1'b1, 3'd2, 32'h0, 32'hFFFF_FFFF);
        xfer(1'b1, 2'b00, 1'b1, 3'd2, 32'h0, 32'hFFFF_FFFF);
        xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h0, $urandom);
        drain();
        check("busy_idle_desel_no_write", last_rd, 32'h11AA_BEEF);

        // three-wait-state slave
        act = 1'b1;
        xfer(1'b1, 2'b10, 1'b1, 3'd2, 32'h14, 32'hCAFE_0005);
        drain();
        lt0 = low_total;
        xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h14, $urandom);
        drain();
        check("wait_low_cycles", 32'(low_total - lt0), 3);
        check("wait_read_data", last_rd, 32'hCAFE_0005);

        m_hburst = 3'b011;
        xfer(1'b1, 2'b10, 1'b1, 3'd2, 32'h20, $urandom);
        s = cyc;
        xfer(1'b1, 2'b11, 1'b1, 3'd2, 32'h24, $urandom);
        xfer(1'b1, 2'b11, 1'b1, 3'd2, 32'h28, $urandom);
        xfer(1'b1, 2'b11, 1'b1, 3'd2, 32'h2C, $urandom);
        drain();
        check("incr4_cycles", 32'(last_done_cyc - s), 16);

        xfer(1'b1, 2'b10, 1'b1, 3'd2, 32'h10, 32'h0BAD_F00D);
        drain();
        xfer(1'b1, 2'b10, 1'b1, 3'd2, 32'h10, 32'h1234_5678);
        #3;
        check("pre_reset_hreadyout", b3.hreadyout, 0);
        hrst = 1'b0;
        #1;
        check("async_reset_hreadyout", b3.hreadyout, 1);
        check("async_reset_hresp", b3.hresp, 0);
        check("async_reset_hrdata", b3.hrdata, 0);
        repeat (2) @(posedge hclk);
        #3 hrst = 1'b1;
        @(posedge hclk);
        #1;
        xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h10, $urandom);
        drain();
        check("reset_abandons_write", last_rd, 32'h0BAD_F00D);

        for (int d = 0; d < 2; d++) begin
            act = (d == 1);
            repeat (250) rand_xfer();
            drain();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
